// File: rtl/demux16_stream_pkg.sv
// Shared constants and types for the 16-channel stream demultiplexer.
package demux_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  // One bit per output channel; at most one bit is ever set.
  typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage : demux_pkg

// File: rtl/demux16_stream_if.sv
// Handshake bundle for the demultiplexer: one producer side, sixteen consumer
// lanes sharing a data bus, plus the delivered-word counter for debug.
interface demux16_stream_if
  import demux_pkg::*;
#(
  parameter int N       = 1,
  parameter int COUNT_W = 16
) ();

  logic [N-1:0]       in_data;
  logic [SEL_W-1:0]   in_switch;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       out_data;
  ch_vec_t            out_valid;
  ch_vec_t            out_ready;
  logic [COUNT_W-1:0] count;

  // Environment side: drives the producer and the consumers.
  modport master (
    output in_data, in_switch, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );

  // Demultiplexer side.
  modport slave (
    input  in_data, in_switch, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );

endinterface : demux16_stream_if

// File: rtl/demux16_stream_decoder4.sv
// 4-to-16 one-hot decoder with enable; all outputs low when disabled.
module decoder4
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output ch_vec_t          onehot
);

  // Raise the single bit addressed by sel, only while enabled.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule : decoder4

// File: rtl/demux16_stream.sv
// Stream demultiplexer: one registered holding stage that steers each word to
// the channel chosen by its select, with a wrapping delivered-word counter.
module demux16_stream
  import demux_pkg::*;
#(
  parameter int N       = 1,
  parameter int COUNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  demux16_stream_if.slave  bus
);

  logic [N-1:0]       hold_data;
  logic [SEL_W-1:0]   hold_sel;
  logic               full;
  logic [COUNT_W-1:0] cnt;
  ch_vec_t            valid_vec;
  logic               out_fire;
  logic               in_fire;
  logic               in_rdy;

  decoder4 u_decoder4 (
    .sel    (hold_sel),
    .en     (full),
    .onehot (valid_vec)
  );

  // Handshake qualifiers: only the addressed channel's ready matters, and
  // in_ready never depends on in_valid.
  always_comb begin
    out_fire = full && bus.out_ready[hold_sel];
    in_rdy   = !full || out_fire;
    in_fire  = bus.in_valid && in_rdy;
  end

  // Holding register: load on accept (also when draining, for bubble-free
  // streaming), empty on delivery, otherwise hold the word stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= 1'b0;
      hold_data <= '0;
      hold_sel  <= '0;
    end else if (in_fire) begin
      full      <= 1'b1;
      hold_data <= bus.in_data;
      hold_sel  <= bus.in_switch;
    end else if (out_fire) begin
      full      <= 1'b0;
    end
  end

  // Delivered-word counter, wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (out_fire) begin
      cnt <= cnt + COUNT_W'(1);
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_data  = hold_data;
  assign bus.out_valid = valid_vec;
  assign bus.count     = cnt;

endmodule : demux16_stream

// File: tb/tb_demux16_stream.sv
// Bench for demux16_stream: directed steps followed by random traffic, all
// checked against a queue-based model of words waiting for delivery.
module tb_demux16_stream;

  localparam int N  = 8;
  localparam int CW = 4;

  typedef struct {
    logic [3:0]   ch;
    logic [N-1:0] data;
  } word_t;

  logic clk;
  logic rst;

  demux16_stream_if #(.N(N), .COUNT_W(CW)) bus ();

  demux16_stream #(.N(N), .COUNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nAsserts = 0;
  int nFail    = 0;

  word_t        pending[$];
  int           delivered;
  logic [N-1:0] lastData;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, check the outputs the model
  // predicts for the current state, then advance the model across the edge.
  task automatic applyStimulus(input logic v, input logic [N-1:0] d,
                               input logic [3:0] s, input logic [15:0] r,
                               input logic rs);
    logic [15:0] expValid;
    logic        expReady;
    logic        deliver;
    logic        accept;
    word_t       w;
    @(negedge clk);
    rst           = rs;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_switch = s;
    bus.out_ready = r;
    #1;
    expValid = 16'h0;
    deliver  = 1'b0;
    if (pending.size() > 0) begin
      expValid = 16'h1 << pending[0].ch;
      deliver  = r[pending[0].ch];
    end
    expReady = (pending.size() == 0) || deliver;
    accept   = v && expReady;
    checkOutput("out_valid", 32'(bus.out_valid), 32'(expValid));
    checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady));
    checkOutput("out_data", 32'(bus.out_data), 32'(lastData));
    checkOutput("count", 32'(bus.count), 32'(delivered % (1 << CW)));
    if (rs) begin
      pending.delete();
      delivered = 0;
      lastData  = '0;
    end else begin
      if (deliver) begin
        void'(pending.pop_front());
        delivered++;
      end
      if (accept) begin
        w.ch   = s;
        w.data = d;
        pending.push_back(w);
        lastData = d;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_switch = '0;
    bus.out_ready = '0;
    delivered     = 0;
    lastData      = '0;

    // Initial reset; internal state is unknown until the first edge, so the
    // model is only trusted from the cycle after.
    @(posedge clk);
    @(posedge clk);
    applyStimulus(1'b0, 8'h00, 4'd0, 16'h0000, 1'b0);

    $display("[TB] single word to channel 5");
    applyStimulus(1'b1, 8'hA5, 4'd5, 16'hFFFF, 1'b0);
    applyStimulus(1'b0, 8'h00, 4'd0, 16'hFFFF, 1'b0);
    applyStimulus(1'b0, 8'h00, 4'd0, 16'hFFFF, 1'b0);
    checkOutput("single_count", 32'(bus.count), 32'd1);

    $display("[TB] backpressure on channel 3");
    applyStimulus(1'b1, 8'h3C, 4'd3, 16'hFFF7, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 8'(8'h50 + i), 4'(i + 8), 16'hFFF7, 1'b0);
    checkOutput("bp_valid", 32'(bus.out_valid), 32'h0008);
    applyStimulus(1'b0, 8'h00, 4'd0, 16'h0008, 1'b0);
    applyStimulus(1'b0, 8'h00, 4'd0, 16'hFFFF, 1'b0);

    $display("[TB] back-to-back 0,15,7,7");
    applyStimulus(1'b1, 8'h10, 4'd0, 16'hFFFF, 1'b0);
    applyStimulus(1'b1, 8'h11, 4'd15, 16'hFFFF, 1'b0);
    applyStimulus(1'b1, 8'h12, 4'd7, 16'hFFFF, 1'b0);
    applyStimulus(1'b1, 8'h13, 4'd7, 16'hFFFF, 1'b0);
    applyStimulus(1'b0, 8'h00, 4'd0, 16'hFFFF, 1'b0);
    applyStimulus(1'b0, 8'h00, 4'd0, 16'hFFFF, 1'b0);
    checkOutput("b2b_count", 32'(bus.count), 32'd6);

    $display("[TB] ready on the wrong channel");
    applyStimulus(1'b1, 8'h99, 4'd9, 16'hFDFF, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 8'hEE, 4'd1, 16'hFDFF, 1'b0);
    checkOutput("wrong_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(1'b0, 8'h00, 4'd0, 16'hFFFF, 1'b0);

    $display("[TB] reset while a word is held");
    applyStimulus(1'b1, 8'h77, 4'd2, 16'h0000, 1'b0);
    applyStimulus(1'b0, 8'h00, 4'd0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 8'h00, 4'd0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 8'h00, 4'd0, 16'hFFFF, 1'b0);
    checkOutput("rst_count", 32'(bus.count), 32'd0);

    $display("[TB] counter wrap with 17 transfers");
    for (int i = 0; i < 17; i++)
      applyStimulus(1'b1, 8'(i), 4'(i), 16'hFFFF, 1'b0);
    applyStimulus(1'b0, 8'h00, 4'd0, 16'hFFFF, 1'b0);
    applyStimulus(1'b0, 8'h00, 4'd0, 16'hFFFF, 1'b0);
    checkOutput("wrap_count", 32'(bus.count), 32'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if ($urandom_range(0, 3) == 0) r = 16'hFFFF;
      applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom),
                    r, 1'($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule : tb_demux16_stream

// File: doc/demux16_stream.md
Name: demux16_stream

Overview:
- Demultiplexer counterpart of the 16:1 mux: routes a single N-bit input stream to one of 16 output channels, selected per word by a 4-bit select.
- Valid/ready handshake on both sides, with one registered holding stage; throughput is one word per cycle.
- Sits between a shared producer (e.g. a bus or ALU result) and 16 per-channel consumers.
- Keeps a wrapping count of delivered words for debug and verification.

Parameters:
- N, 1, data width in bits (N >= 1)
- COUNT_W, 16, width of the delivered-word counter

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  N  input word
- in_switch  input  4  destination channel, 0..15
- in_valid  input  1  producer offers in_data/in_switch this cycle
- in_ready  output  1  block accepts this cycle; a transfer happens when in_valid && in_ready
- out_data  output  N  held word, shared by all channels; qualified only by out_valid
- out_valid  output  16  one-hot; bit k set means channel k holds a word
- out_ready  input  16  per-channel consumer ready
- count  output  COUNT_W  number of completed output transfers, wraps modulo 2^COUNT_W

Behaviour:
- State: holding register (data, 4-bit select, full flag) and count.
- Reset (rst=1 at the clock edge):
  - full=0, so out_valid=16'h0000.
  - out_data=0, held select=0, count=0.
  - in_ready=1 in the first cycle after reset.
  - A word held when reset arrives is discarded and not counted.
- out_valid = full ? decode(held select) : 0. It is always one-hot or zero.
- out_fire = full && out_ready[held select]. The out_ready bits of other channels are ignored.
- in_ready = !full || out_fire. This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- in_fire = in_valid && in_ready.
- Per clock edge (rst=0):
  - in_fire: load data and select, full=1. Covers simultaneous out_fire, which gives back-to-back words with no bubble.
  - out_fire && !in_fire: full=0.
  - Otherwise: hold. The held data and select stay stable while out_valid is set and out_ready is low.
- Latency: a word accepted in cycle t is presented in cycle t+1. Minimum occupancy is one cycle.
- count increments by 1 on each out_fire. It wraps from 2^COUNT_W-1 to 0 with no flag.
- in_switch is sampled only on in_fire. Changing it while the register is full has no effect on the held word.
- out_data keeps its last value after full drops; consumers must qualify it with out_valid.
- X on in_data/in_switch while in_valid=0 must not propagate into state.

Decomposition:
- Package demux_pkg holds:
  - localparam NUM_CH=16 and SEL_W=4;
  - a typedef for the one-hot channel vector, logic [NUM_CH-1:0].
- Sub-module decoder4 (combinational 4-to-16 one-hot decoder with enable): used for out_valid generation, with enable=full.
- Top level: holding register, handshake logic, count.

Test Plan:
- Reset: assert rst for 2 cycles mid-stream with full=1 -> next cycle out_valid=0, count=0, in_ready=1.
- Single word: in_data=8'hA5, in_switch=5, in_valid=1 for 1 cycle, out_ready=16'hFFFF -> next cycle out_valid=16'h0020, out_data=8'hA5; following cycle out_valid=0, count=1.
- Backpressure: word to channel 3 with out_ready=16'hFFF7 for 4 cycles -> out_valid=16'h0008 and out_data stable, in_ready=0, count unchanged; then out_ready[3]=1 -> transfer, count+1.
- Back-to-back: words to channels 0,15,7,7 on consecutive cycles, all ready -> out_valid sequence 0001,8000,0080,0080 with no bubbles, count=4.
- Wrong-channel ready: held word for channel 9, out_ready=16'hFDFF -> no transfer, in_ready=0.
- Counter wrap: COUNT_W=4, 17 transfers -> count=1.
